// File: rtl/pwm_bridge_driver.sv
// Half-bridge PWM generator: period counter, double-buffered duty handshake,
// dead-time gate FSM and a latching fault shutdown.
module pwm_bridge_driver #(
  parameter int unsigned W        = 16,
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned DEADTIME = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] duty_in,
  input  logic         duty_vld,
  output logic         duty_rdy,
  input  logic         fault,
  input  logic         fault_clr,
  output logic         hs,
  output logic         ls,
  output logic         period_start,
  output logic         faulted,
  output logic [W-1:0] cnt
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DEAD,
    ST_HS_ON,
    ST_LS_ON,
    ST_FAULT
  } state_t;

  localparam logic [W-1:0] PER     = W'(PERIOD);
  localparam logic [W-1:0] LAST    = W'(PERIOD - 1);
  localparam logic [7:0]   DT_LOAD = 8'(DEADTIME - 1);

  state_t       state;
  logic [W-1:0] shadow;
  logic [W-1:0] duty_act;
  logic [7:0]   dead_cnt;
  logic         target;

  logic         run;
  logic         wrap;
  logic         raw;
  logic         start;
  logic         xfer;
  logic [W-1:0] duty_clamped;

  // A fault request stops the counter in the same cycle it arrives,
  // before faulted has had a chance to register.
  assign run          = en & ~fault & ~faulted;
  assign wrap         = run & (cnt == LAST);
  assign raw          = cnt < duty_act;
  assign start        = (state == ST_OFF) & en & ~fault;
  assign xfer         = duty_vld & duty_rdy;
  assign duty_clamped = (duty_in > PER) ? PER : duty_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (!run || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

  // duty_rdy doubles as the shadow-empty flag, so a transfer and a load
  // can never coincide: a wrap only consumes a full shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      duty_act <= '0;
      duty_rdy <= 1'b1;
    end else if (xfer) begin
      shadow   <= duty_clamped;
      duty_rdy <= 1'b0;
    end else if (!duty_rdy && (wrap || start)) begin
      duty_act <= shadow;
      duty_rdy <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      hs       <= 1'b0;
      ls       <= 1'b0;
      faulted  <= 1'b0;
      dead_cnt <= '0;
      target   <= 1'b0;
    end else if (fault) begin
      state   <= ST_FAULT;
      faulted <= 1'b1;
      hs      <= 1'b0;
      ls      <= 1'b0;
    end else if (state == ST_FAULT) begin
      if (fault_clr) begin
        state   <= ST_OFF;
        faulted <= 1'b0;
      end
    end else if (!en) begin
      state <= ST_OFF;
      hs    <= 1'b0;
      ls    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state    <= ST_DEAD;
          target   <= raw;
          dead_cnt <= DT_LOAD;
        end
        ST_HS_ON: begin
          if (!raw) begin
            state    <= ST_DEAD;
            target   <= 1'b0;
            dead_cnt <= DT_LOAD;
            hs       <= 1'b0;
          end
        end
        ST_LS_ON: begin
          if (raw) begin
            state    <= ST_DEAD;
            target   <= 1'b1;
            dead_cnt <= DT_LOAD;
            ls       <= 1'b0;
          end
        end
        ST_DEAD: begin
          target <= raw;
          if (dead_cnt == 8'd0) begin
            state <= target ? ST_HS_ON : ST_LS_ON;
            hs    <= target;
            ls    <= ~target;
          end else begin
            dead_cnt <= dead_cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_OFF;
          hs    <= 1'b0;
          ls    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_bridge_driver.sv
// Directed bench for pwm_bridge_driver: per-period gate statistics go through
// an expectation queue; overlap and dead-window length are watched every cycle.
module tb_pwm_bridge_driver;

  localparam int W  = 16;
  localparam int PR = 100;
  localparam int DT = 5;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] duty_in;
  logic         duty_vld;
  logic         duty_rdy;
  logic         fault;
  logic         fault_clr;
  logic         hs;
  logic         ls;
  logic         period_start;
  logic         faulted;
  logic [W-1:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int hs_n;
    int ls_n;
    int dead_n;
    int ps_n;
  } per_t;

  per_t exp_q[$];

  pwm_bridge_driver #(.W(W), .PERIOD(PR), .DEADTIME(DT)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .duty_vld     (duty_vld),
    .duty_rdy     (duty_rdy),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .hs           (hs),
    .ls           (ls),
    .period_start (period_start),
    .faulted      (faulted),
    .cnt          (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_per(input int h, input int l, input int d, input int p);
    per_t e;
    e.hs_n   = h;
    e.ls_n   = l;
    e.dead_n = d;
    e.ps_n   = p;
    exp_q.push_back(e);
  endtask

  // Align to a period_start pulse, then tally one full period of gate states.
  task automatic measure(input string tag);
    per_t e;
    per_t got;
    int   n;
    n = 0;
    while (!period_start && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_ps_wait"}, period_start, 1);
    got = '{0, 0, 0, 0};
    for (int i = 0; i < PR; i++) begin
      if (hs) got.hs_n++;
      else if (ls) got.ls_n++;
      else got.dead_n++;
      if (period_start) got.ps_n++;
      step();
    end
    e = exp_q.pop_front();
    chk({tag, "_hs"},   got.hs_n,   e.hs_n);
    chk({tag, "_ls"},   got.ls_n,   e.ls_n);
    chk({tag, "_dead"}, got.dead_n, e.dead_n);
    chk({tag, "_ps"},   got.ps_n,   e.ps_n);
  endtask

  task automatic load_duty(input int d);
    duty_in  = W'(d);
    duty_vld = 1'b1;
    step();
    duty_vld = 1'b0;
  endtask

  int last_on = 0;
  int low_run = 0;
  int cur_on  = 0;

  always @(negedge clk) begin
    if (rst) begin
      last_on = 0;
      low_run = 0;
    end else begin
      chk("no_overlap", hs & ls, 0);
      if (hs || ls) begin
        cur_on = hs ? 1 : 2;
        if (last_on != 0 && last_on != cur_on) chk("dead_len", low_run >= DT, 1);
        last_on = cur_on;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    en        = 1'b0;
    duty_in   = '0;
    duty_vld  = 1'b0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    step();
    step();
    chk("rst_cnt", cnt, 0);
    chk("rst_hs", hs, 0);
    chk("rst_ls", ls, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_faulted", faulted, 0);
    chk("rst_rdy", duty_rdy, 1);
    rst = 1'b0;
    step();

    // Steady duty 30 loaded before enable
    load_duty(30);
    chk("pre_en_rdy", duty_rdy, 0);
    chk("pre_en_cnt", cnt, 0);
    en = 1'b1;
    step();
    chk("first_en_rdy", duty_rdy, 1);
    chk("first_en_cnt", cnt, 1);
    push_per(25, 65, 10, 1);
    push_per(25, 65, 10, 1);
    measure("steady1");
    measure("steady2");

    // Double buffer: write 60 mid-period
    repeat (40) step();
    chk("db_cnt40", cnt, 40);
    load_duty(60);
    chk("db_rdy_drop", duty_rdy, 0);
    chk("db_hs_still30", hs, 0);
    repeat (9) step();
    chk("db_ls_cnt50", ls, 1);
    repeat (49) step();
    chk("db_cnt99", cnt, 99);
    chk("db_rdy_held", duty_rdy, 0);
    step();
    chk("db_rdy_wrap", duty_rdy, 1);
    chk("db_cnt0", cnt, 0);
    push_per(55, 35, 10, 1);
    measure("dbuf60");

    // Extremes
    load_duty(0);
    push_per(0, PR, 0, 1);
    measure("duty0");
    load_duty(150);
    push_per(94, 1, 5, 1);
    push_per(PR, 0, 0, 1);
    measure("duty150a");
    measure("duty150b");

    // Fault mid HS_ON
    load_duty(30);
    push_per(31, 64, 5, 1);
    measure("pre_fault");
    repeat (10) step();
    chk("flt_pre_hs", hs, 1);
    fault = 1'b1;
    step();
    chk("flt_hs", hs, 0);
    chk("flt_ls", ls, 0);
    chk("flt_faulted", faulted, 1);
    chk("flt_cnt", cnt, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("flt_clr_ignored", faulted, 1);
    chk("flt_cnt_held", cnt, 0);
    repeat (3) step();
    fault = 1'b0;
    step();
    chk("flt_no_clr", faulted, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("flt_cleared", faulted, 0);
    chk("flt_clr_cnt", cnt, 0);
    n = 0;
    while (!hs && n < 20) begin
      step();
      n++;
    end
    chk("flt_resume_delay", n, 6);
    chk("flt_resume_cnt", cnt, 6);
    push_per(25, 65, 10, 1);
    measure("post_fault");

    // Short pulse narrower than the dead time
    load_duty(3);
    push_per(0, 95, 5, 1);
    push_per(0, 95, 5, 1);
    measure("short1");
    measure("short2");

    // Random duty traffic; the negedge monitor checks the invariants
    repeat (1500) begin
      duty_vld = ($urandom_range(0, 7) == 0);
      duty_in  = W'($urandom_range(0, 120));
      step();
    end
    duty_vld = 1'b0;

    // Asynchronous reset mid-period with hs on
    n = 0;
    while (!duty_rdy && n < 300) begin
      step();
      n++;
    end
    chk("rdy_wait", duty_rdy, 1);
    load_duty(60);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 300);
    chk("ar_ps_wait", period_start, 1);
    repeat (50) step();
    chk("ar_cnt50", cnt, 50);
    chk("ar_hs_on", hs, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt", cnt, 0);
    chk("ar_hs", hs, 0);
    chk("ar_ls", ls, 0);
    chk("ar_ps", period_start, 0);
    chk("ar_faulted", faulted, 0);
    chk("ar_rdy", duty_rdy, 1);
    step();
    rst = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_bridge_driver.md
Name: pwm_bridge_driver

Overview:
- Synthesizable half-bridge PWM generator with dead-time insertion.
- Produces complementary high-side/low-side gate commands; the bridge model turns these into the drive voltage u for the RLC plant stage downstream.
- Duty updates arrive through a valid/ready handshake. They are double-buffered and applied only at a period boundary.
- A fault input forces both switches off and latches.

Parameters:
- W, 16, counter and duty width in bits.
- PERIOD, 1000, PWM period in clk cycles. Legal range 2..2^W-1.
- DEADTIME, 20, cycles with both gates low on every transition. Legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable; low = counter held, gates off
- duty_in  in  W  requested high-side on-time in cycles
- duty_vld  in  1  duty_in valid
- duty_rdy  out  1  shadow register empty, able to accept
- fault  in  1  overcurrent/fault request, level
- fault_clr  in  1  clears latched fault; honoured only while fault=0
- hs  out  1  high-side gate command
- ls  out  1  low-side gate command
- period_start  out  1  one-cycle pulse when cnt wraps to 0
- faulted  out  1  latched fault status
- cnt  out  W  current period counter

Behaviour:
- Reset values: cnt=0, hs=0, ls=0, period_start=0, faulted=0, duty_rdy=1, duty_act=0, shadow empty, state=OFF, dead counter=0.
- Counter:
  - en=1 and not faulted: cnt counts 0..PERIOD-1, then wraps to 0.
  - Otherwise cnt=0.
  - period_start=1 in the cycle cnt transitions PERIOD-1 -> 0.
- Duty handshake:
  - Transfer occurs on duty_vld & duty_rdy.
  - On transfer: shadow <= min(duty_in, PERIOD); duty_rdy <= 0.
  - At wrap (cnt==PERIOD-1 with counting active): if shadow is full, duty_act <= shadow and duty_rdy <= 1 in the same cycle.
  - A transfer and a wrap in the same cycle: the new value goes to shadow and does not load until the next wrap.
  - Shadow accepts while en=0.
  - On the first enable, duty_act loads the shadow immediately, without waiting for a wrap.
- Raw compare: raw = (cnt < duty_act).
  - duty_act=0 gives raw permanently 0.
  - duty_act=PERIOD gives raw permanently 1.
- Gate FSM:
  - States: OFF, DEAD, HS_ON, LS_ON, FAULT.
  - hs=1 only in HS_ON; ls=1 only in LS_ON. Outputs are registered state decodes, so latency is 1 cycle from the raw change.
  - OFF: on en=1 go to DEAD, target=raw, dead counter=DEADTIME-1.
  - HS_ON: on raw=0 go to DEAD, target=LS, load counter.
  - LS_ON: on raw=1 go to DEAD, target=HS, load counter.
  - DEAD: counter decrements each cycle.
    - While in DEAD, target tracks raw; the counter is not restarted.
    - At counter==0: go to HS_ON if target=HS, otherwise LS_ON.
    - Both gates stay low for exactly DEADTIME cycles per entry.
  - Any state with en=0: go to OFF next cycle.
  - Any state with fault=1: go to FAULT next cycle, faulted<=1. Fault has priority over en and over a dead-time expiry in the same cycle.
  - FAULT: gates low, cnt held 0. Exits to OFF only when fault=0 & fault_clr=1, which clears faulted. fault_clr while fault=1 is ignored.
- Invariants:
  - hs & ls is never 1.
  - Every hs<->ls handover has >= DEADTIME cycles of both low.
- Short pulses: a high or low interval shorter than DEADTIME may produce no on-pulse for that side. This is accepted behaviour.
- Reset asserted mid-period: all outputs return to reset values immediately, asynchronously.

Test Plan:
- Steady duty: PERIOD=100, DEADTIME=5, duty 30 loaded before en.
  - Each period: hs high 25 cycles, ls high 65, two 5-cycle dead windows.
  - period_start every 100 cycles.
- Double buffer: duty 30 running, write 60 at cnt=40.
  - duty_rdy drops 1 cycle after the transfer.
  - Current period stays 30; the next period shows hs=55.
  - duty_rdy returns to 1 at the wrap.
- Extremes: duty=0 gives ls constantly high, hs never. duty=150 is clamped to 100, giving hs constantly high. Neither case has a dead window after the first.
- Fault mid-HS_ON at cnt=10:
  - Next cycle hs=ls=0, faulted=1, cnt=0.
  - fault_clr while fault=1 has no effect.
  - Drop fault, pulse fault_clr: faulted=0, then DEAD for 5 cycles and normal operation resumes.
- Short pulse: duty=3 with DEADTIME=5 gives hs never asserted and ls off for exactly 5 cycles per period. A random-duty run checks !(hs&ls) and dead-window length on every cycle.
- Async reset: assert rst at cnt=50 with hs=1. All outputs go to reset values before the next clk edge; duty_rdy=1.
